// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: select-mode constants and select-width helper for mux_rr_stream
package mux_rr_pkg;
  localparam int SEL_EXT = 0;
  localparam int SEL_RR = 1;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  localparam logic [N-1:0] ONE = 1;
  // walk from farthest to nearest so the closest requester after ptr wins last
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = W'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    grant = any ? ONE << idx : '0;
  end
endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel stream mux with external or round-robin select, registered output.
// Define MUX_RR_STREAM_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_rr_stream
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  parameter int SEL_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH-1:0]           in_last,
  output logic [N_CH-1:0]           in_ready,
  input  logic [sel_w(N_CH)-1:0]    sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [sel_w(N_CH)-1:0]    out_ch
);
  localparam int SW = sel_w(N_CH);
  localparam bit EXT = (SEL_MODE == SEL_EXT);
  localparam logic [N_CH-1:0] ONE = 1;
  logic [N_CH-1:0] arb_grant;
  logic [SW-1:0] arb_idx, gidx, ptr_q, ptr_d, out_ch_q, out_ch_d;
  logic arb_any, gany, load, xfer, sel_ok, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic lock_q;
  logic [SW-1:0] lock_ch_q;
  rr_arbiter #(.N(N_CH), .W(SW)) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
  logic lock_d;
  logic [SW-1:0] lock_ch_d;
  // a non-last beat opens the lock; the last beat of the same channel releases it
  assign lock_d = xfer ? !in_last[gidx] : lock_q;
  assign lock_ch_d = xfer ? gidx : lock_ch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  logic unused_last;
  assign lock_q = 1'b0;
  assign lock_ch_q = '0;
  assign unused_last = ^in_last;
`endif
  assign load = !out_valid_q || out_ready;
  assign sel_ok = int'(sel) < N_CH;
  assign gidx = lock_q ? lock_ch_q : EXT ? sel : arb_idx;
  assign gany = lock_q ? in_valid[lock_ch_q] : EXT ? sel_ok && in_valid[sel] : arb_any;
  assign in_ready = (load && gany) ? ((lock_q || EXT) ? ONE << gidx : arb_grant) : '0;
  assign xfer = load && gany;
  always_comb begin
    out_valid_d = xfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d = xfer ? in_data[int'(gidx)*WIDTH +: WIDTH] : out_data_q;
    out_ch_d = xfer ? gidx : out_ch_q;
    ptr_d = xfer ? gidx : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      ptr_q <= SW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed vectors for round-robin (N=4) and external-select (N=4, N=3) muxes
module tb_mux_rr_stream;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  logic [31:0] rr_data, e_data;
  logic [3:0] rr_valid, rr_last, rr_ready, e_valid, e_ready;
  logic [1:0] rr_sel, e_sel, rr_ch, e_ch, e3_sel, e3_ch;
  logic [7:0] rr_odata, e_odata, e3_odata;
  logic rr_ovalid, rr_oready, e_ovalid, e_oready, e3_ovalid, e3_oready;
  logic [23:0] e3_data;
  logic [2:0] e3_valid, e3_ready;
  mux_rr_stream #(.N_CH(4), .WIDTH(8), .SEL_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(rr_data), .in_valid(rr_valid), .in_last(rr_last),
    .in_ready(rr_ready), .sel(rr_sel), .out_data(rr_odata), .out_valid(rr_ovalid),
    .out_ready(rr_oready), .out_ch(rr_ch)
  );
  mux_rr_stream #(.N_CH(4), .WIDTH(8), .SEL_MODE(0)) u_ext (
    .clk(clk), .rst_n(rst_n), .in_data(e_data), .in_valid(e_valid), .in_last(4'b1111),
    .in_ready(e_ready), .sel(e_sel), .out_data(e_odata), .out_valid(e_ovalid),
    .out_ready(e_oready), .out_ch(e_ch)
  );
  mux_rr_stream #(.N_CH(3), .WIDTH(8), .SEL_MODE(0)) u_ext3 (
    .clk(clk), .rst_n(rst_n), .in_data(e3_data), .in_valid(e3_valid), .in_last(3'b111),
    .in_ready(e3_ready), .sel(e3_sel), .out_data(e3_odata), .out_valid(e3_ovalid),
    .out_ready(e3_oready), .out_ch(e3_ch)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rr_data = 32'hA3A2A1A0; rr_valid = '0; rr_last = '0; rr_sel = '0; rr_oready = 1'b0;
    e_data = '0; e_valid = '0; e_sel = '0; e_oready = 1'b0;
    e3_data = 24'hC2C1C0; e3_valid = '0; e3_sel = '0; e3_oready = 1'b0;
    tick();
    tick();
    chk("rst_valid", rr_ovalid, 0);
    chk("rst_data", rr_odata, 0);
    chk("rst_ch", rr_ch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_valid = 4'hF;
    rr_oready = 1'b1;
    #1;
    chk("rr_first_ready", rr_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_seq_valid", rr_ovalid, 1);
      chk("rr_seq_ch", rr_ch, i % 4);
      chk("rr_seq_data", rr_odata, 8'hA0 + i % 4);
      chk("rr_seq_ready", rr_ready, 4'b0001 << ((i + 1) % 4));
    end
    rr_oready = 1'b0;
    #1;
    chk("stall_ready", rr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", rr_ovalid, 1);
      chk("stall_ch", rr_ch, 3);
      chk("stall_data", rr_odata, 8'hA3);
      chk("stall_ready", rr_ready, 0);
    end
    rr_oready = 1'b1;
    #1;
    chk("drain_ready", rr_ready, 4'b0001);
    tick();
    chk("drain_ch", rr_ch, 0);
    chk("drain_data", rr_odata, 8'hA0);
    rr_valid = '0;
    tick();
    chk("empty_valid", rr_ovalid, 0);
    rr_valid = 4'b1010;
    #1;
    chk("part_ready1", rr_ready, 4'b0010);
    tick();
    chk("part_ch1", rr_ch, 1);
    chk("part_ready3", rr_ready, 4'b1000);
    tick();
    chk("part_ch3", rr_ch, 3);
    chk("part_wrap", rr_ready, 4'b0010);
    tick();
    chk("part_ch1b", rr_ch, 1);
    rr_oready = 1'b0;
    rr_valid = 4'hF;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", rr_ovalid, 0);
    chk("async_data", rr_odata, 0);
    chk("async_ch", rr_ch, 0);
    rr_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", rr_ovalid, 0);
    rr_valid = 4'hF;
    rr_oready = 1'b1;
    #1;
    chk("post_rst_ready", rr_ready, 4'b0001);
    tick();
    chk("post_rst_ch", rr_ch, 0);
    chk("post_rst_data", rr_odata, 8'hA0);
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    rr_valid = 4'b0111;
    rr_last = 4'b0000;
    #1;
    chk("lock_ready", rr_ready, 4'b0010);
    tick();
    chk("lock_b1", rr_ch, 1);
    chk("lock_hold", rr_ready, 4'b0010);
    tick();
    chk("lock_b2", rr_ch, 1);
    rr_last = 4'b0010;
    tick();
    chk("lock_b3", rr_ch, 1);
    rr_last = 4'b0000;
    #1;
    chk("unlock_ready", rr_ready, 4'b0100);
    tick();
    chk("unlock_ch", rr_ch, 2);
`endif
    rr_valid = '0;
    e_data = 32'h5AA51122;
    e_sel = 2'd2;
    e_valid = 4'b1011;
    e_oready = 1'b1;
    #1;
    chk("ext_noready", e_ready, 0);
    tick();
    chk("ext_novalid", e_ovalid, 0);
    e_valid = 4'b0100;
    #1;
    chk("ext_ready", e_ready, 4'b0100);
    tick();
    chk("ext_valid", e_ovalid, 1);
    chk("ext_data", e_odata, 8'hA5);
    chk("ext_ch", e_ch, 2);
    e_sel = 2'd3;
    e_valid = 4'b1000;
    tick();
    chk("ext_data3", e_odata, 8'h5A);
    chk("ext_ch3", e_ch, 3);
    e_valid = '0;
    e3_sel = 2'd3;
    e3_valid = 3'b111;
    e3_oready = 1'b1;
    #1;
    chk("e3_oob_ready", e3_ready, 0);
    tick();
    chk("e3_oob_valid", e3_ovalid, 0);
    e3_sel = 2'd1;
    #1;
    chk("e3_ready1", e3_ready, 3'b010);
    tick();
    chk("e3_ch1", e3_ch, 1);
    chk("e3_data1", e3_odata, 8'hC1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 SHALL have parameter SEL_MODE, default 1: 0 = external select, 1 = round-robin.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, N_CH*WIDTH, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, N_CH, per-channel valid.
REQ-008 SHALL have port in_last, input, N_CH, per-channel end-of-packet flag.
REQ-009 SHALL have port in_ready, output, N_CH, per-channel ready.
REQ-010 SHALL have port sel, input, SW=max(1,clog2(N_CH)), channel select, used only when SEL_MODE=0.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.
REQ-014 SHALL have port out_ch, output, SW, source channel of out_data.

Function
REQ-015 SHALL transfer an input beat when in_valid[i] && in_ready[i]; SHALL transfer an output beat when out_valid && out_ready.
REQ-016 SHALL assert load = !out_valid || out_ready; at most one in_ready bit high per cycle, and only when load=1.
REQ-017 SHALL register the granted beat into out_data/out_ch and set out_valid on the cycle after transfer (latency 1); full throughput of one beat per cycle when out_ready held high.
REQ-018 SHALL clear out_valid when an output transfer occurs with no input transfer in the same cycle.
REQ-019 SHALL hold out_data, out_ch, out_valid stable while out_valid && !out_ready.
REQ-020 SEL_MODE=0: SHALL grant channel sel iff in_valid[sel]; sel >= N_CH SHALL produce no grant.
REQ-021 SEL_MODE=1: SHALL grant the first valid channel searching from ptr+1 upward, wrapping N_CH-1 -> 0.
REQ-022 SEL_MODE=1: SHALL update ptr to the granted channel only on an input transfer; no transfer leaves ptr unchanged.
REQ-023 in_ready SHALL be combinational from in_valid, sel, ptr, lock state and out_ready; out_data and out_ch SHALL be registered.

Reset
REQ-024 On rst_n low SHALL immediately force out_valid=0, out_data=0, out_ch=0, ptr=N_CH-1 (channel 0 has first priority), lock cleared.
REQ-025 Reset mid-packet or with a stalled beat SHALL discard that beat; no beat is emitted after deassertion until a new input transfer.

Configuration
REQ-026 Macro MUX_RR_STREAM_PKT_LOCK_EN defined: after an input transfer with in_last=0, grant SHALL lock to that channel; other channels and sel changes ignored until that channel transfers a beat with in_last=1, which clears the lock in the same cycle.
REQ-027 Macro undefined: in_last SHALL be ignored and arbitration SHALL occur per beat.

Structure
REQ-028 Package mux_rr_pkg SHALL hold the SEL_MODE constants (SEL_EXT=0, SEL_RR=1) and the select-width function.
REQ-029 Round-robin grant logic SHALL live in sub-module rr_arbiter (inputs req, ptr; outputs grant one-hot, grant index, any).

Verification
REQ-030 N_CH=4, SEL_MODE=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-031 SEL_MODE=0, sel=2, in_valid=4'b1011 -> no in_ready, out_valid stays 0; then in_valid[2]=1, data 8'hA5 -> out_data=8'hA5, out_ch=2 next cycle.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch unchanged, in_ready=0; out_ready=1 -> drain, next beat loads same cycle.
REQ-033 With PKT_LOCK_EN: ch1 sends 3-beat packet (last on beat 3) while ch0/ch2 valid -> out_ch=1,1,1 then arbitration resumes at ch2.
REQ-034 Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0 same cycle, out_data=0, next grant after release is ch0 in RR mode.
REQ-035 N_CH=3, SEL_MODE=0, sel=3 -> in_ready=0 on all channels, no output.
